// File: rtl/prng_lfsr16_core_if.sv
// Output stream of the 16-bit LFSR generator.
// The master presents pseed with out_valid; the slave returns out_ready.
interface prng_lfsr16_core_if #(
    parameter int WIDTH = 16
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] pseed;

    modport master (
        output out_valid,
        output pseed,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  pseed,
        output out_ready
    );
endinterface

// File: rtl/prng_lfsr16_core.sv
// 16-bit Galois LFSR with seed load, zero-seed guard and valid/ready output.
// Optional PRNG_PERIOD_CNT_EN adds a step counter and a period_wrap pulse.
module prng_lfsr16_core #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             run,
    output logic             zero_seed,
`ifdef PRNG_PERIOD_CNT_EN
    output logic             period_wrap,
`endif
    prng_lfsr16_core_if.master strm
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] pseed_q;
    logic [WIDTH-1:0] pseed_d;
    logic [WIDTH-1:0] step;
    logic             zero_d;
    logic             seed_zero;
    logic             hs;

    assign strm.out_valid = (state_q == RUN);
    assign strm.pseed     = pseed_q;

    assign hs        = (state_q == RUN) && strm.out_ready;
    assign seed_zero = (seed_in == '0);
    assign step      = (pseed_q >> 1) ^ (pseed_q[0] ? TAPS : '0);

    // A load overrides both the step and any state transition.
    always_comb begin
        state_d = state_q;
        pseed_d = pseed_q;
        zero_d  = 1'b0;
        if (seed_load) begin
            pseed_d = seed_zero ? DEFAULT_SEED : seed_in;
            zero_d  = seed_zero;
        end else begin
            if (hs) begin
                pseed_d = step;
            end
            unique case (state_q)
                IDLE: if (run)  state_d = RUN;
                RUN:  if (!run) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pseed_q   <= DEFAULT_SEED;
            zero_seed <= 1'b0;
        end else begin
            state_q   <= state_d;
            pseed_q   <= pseed_d;
            zero_seed <= zero_d;
        end
    end

`ifdef PRNG_PERIOD_CNT_EN
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] seed_ref_q;
    logic             wrap_hit;

    assign cnt_inc  = cnt_q + 1'b1;
    assign wrap_hit = hs && !seed_load && (step == seed_ref_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            seed_ref_q  <= DEFAULT_SEED;
            period_wrap <= 1'b0;
        end else begin
            period_wrap <= wrap_hit;
            if (seed_load) begin
                cnt_q      <= '0;
                seed_ref_q <= pseed_d;
            end else if (wrap_hit) begin
                cnt_q <= '0;
            end else if (hs) begin
                cnt_q <= cnt_inc;
            end
        end
    end

`ifndef SYNTHESIS
    // A maximal-length TAPS mask must return to the seed after exactly 2^16-1 steps.
    always @(posedge clk) begin
        if (rst_n && wrap_hit) begin
            assert (cnt_inc == {WIDTH{1'b1}})
            else $error("period length %0d", cnt_inc);
        end
    end
`endif
`endif

endmodule
